iob_byte_offset2wstrb_wr: RTL and testbench



---
 rtl/iob_byte_offset2wstrb_pkg.sv | 22 ++
 rtl/iob_byte_offset2wstrb_wr_if.sv | 35 +++
 rtl/iob_offset2wstrb.sv | 22 ++
 rtl/iob_byte_offset2wstrb_wr.sv | 137 +++++++++++++
 tb/tb_iob_byte_offset2wstrb_wr.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_byte_offset2wstrb_pkg.sv
// Shared constants and types for the byte-offset to write-strobe beat generator.
// BUS_BYTES is the default bus width. OFF_W and NB_W are the matching widths of
// the in-word byte offset and of the byte count for that default.
package iob_byte_offset2wstrb_pkg;

  localparam int unsigned BUS_BYTES = 4;

  // Number of bits needed to index a byte lane inside one bus word.
  function automatic int unsigned offWidth(input int unsigned nBytes);
    return $clog2(nBytes);
  endfunction

  localparam int unsigned OFF_W = offWidth(BUS_BYTES);
  localparam int unsigned NB_W  = OFF_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

endpackage

// File: rtl/iob_byte_offset2wstrb_wr_if.sv
// Request and beat channels of the write-side beat generator.
// Signal names follow the generator's own point of view: _i are driven by the
// master side and _o are driven by the generator.
interface iob_byte_offset2wstrb_wr_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned ADDR_W = 32
);

  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [ADDR_W-1:0]    req_addr_i;
  logic [$clog2(N):0]   req_nbytes_i;
  logic [8*N-1:0]       req_data_i;

  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [ADDR_W-1:0]    out_addr_o;
  logic [N-1:0]         out_wstrb_o;
  logic [8*N-1:0]       out_data_o;

  logic                 busy_o;

  // The beat generator itself.
  modport slave (
    input  req_valid_i, req_addr_i, req_nbytes_i, req_data_i, out_ready_i,
    output req_ready_o, out_valid_o, out_addr_o, out_wstrb_o, out_data_o, busy_o
  );

  // The byte-oriented requester and beat consumer.
  modport master (
    output req_valid_i, req_addr_i, req_nbytes_i, req_data_i, out_ready_i,
    input  req_ready_o, out_valid_o, out_addr_o, out_wstrb_o, out_data_o, busy_o
  );

endinterface

// File: rtl/iob_offset2wstrb.sv
// Turns a byte offset and a byte count into a two-word strobe mask.
// Bit i of m2_o is set when byte lane i (counting across two consecutive words)
// is written. This is the inverse of the strobe-to-offset encoder and is also
// usable for read-side byte selection. nb_i is expected to be already clamped
// to N by the caller, so the mask never extends past the second word.
module iob_offset2wstrb #(
  parameter int unsigned N = 4
) (
  input  logic [$clog2(N)-1:0] off_i,
  input  logic [$clog2(N):0]   nb_i,
  output logic [2*N-1:0]       m2_o
);

  // A lane is strobed when it lies in the window [off, off + nb).
  always_comb begin
    m2_o = '0;
    for (int i = 0; i < 2 * int'(N); i++) begin
      m2_o[i] = (i >= int'(off_i)) && (i < int'(off_i) + int'(nb_i));
    end
  end

endmodule

// File: rtl/iob_byte_offset2wstrb_wr.sv
// Write-side beat generator: takes one byte-addressed write request and emits
// one or two word-aligned beats with byte strobes and lane-shifted data. A
// second beat is produced only when the bytes spill past the first word.
module iob_byte_offset2wstrb_wr
  import iob_byte_offset2wstrb_pkg::*;
#(
  parameter int unsigned N      = BUS_BYTES,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  iob_byte_offset2wstrb_wr_if.slave    bus
);

  localparam int unsigned OFF_BITS = offWidth(N);
  localparam int unsigned NB_BITS  = OFF_BITS + 1;
  localparam int unsigned DW       = 8 * N;

  logic [OFF_BITS-1:0] off_d;
  logic [NB_BITS-1:0]  nb_d;
  logic [2*N-1:0]      m2_d;
  logic [2*DW-1:0]     shifted_d;
  logic [2*DW-1:0]     d2_d;
  logic [ADDR_W-1:0]   base_d;
  logic                split_d;
  logic                accept_d;
  logic                hs_d;

  state_e              state_q;
  logic                req_ready_q;
  logic                out_valid_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [N-1:0]        out_wstrb_q;
  logic [DW-1:0]       out_data_q;
  logic [ADDR_W-1:0]   b1_addr_q;
  logic [N-1:0]        b1_wstrb_q;
  logic [DW-1:0]       b1_data_q;
  logic                split_q;

  // Byte offset inside the word and byte count clamped to one full word.
  always_comb begin
    off_d = bus.req_addr_i[OFF_BITS-1:0];
    nb_d  = (bus.req_nbytes_i > NB_BITS'(N)) ? NB_BITS'(N) : bus.req_nbytes_i;
  end

  iob_offset2wstrb #(
    .N (N)
  ) u_offset2wstrb (
    .off_i (off_d),
    .nb_i  (nb_d),
    .m2_o  (m2_d)
  );

  // Shift the payload into its lanes across two words and blank unwritten lanes.
  always_comb begin
    shifted_d = {{DW{1'b0}}, bus.req_data_i} << {off_d, 3'b000};
    d2_d      = '0;
    for (int i = 0; i < 2 * int'(N); i++) begin
      d2_d[8*i +: 8] = m2_d[i] ? shifted_d[8*i +: 8] : 8'h00;
    end
  end

  // Word base address, split detection and the two handshakes.
  always_comb begin
    base_d   = {bus.req_addr_i[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
    split_d  = |m2_d[2*N-1:N];
    accept_d = bus.req_valid_i & req_ready_q;
    hs_d     = out_valid_q & bus.out_ready_i;
  end

  // Request/beat sequencer: loads both beats on accept, then walks through them.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_wstrb_q <= '0;
      out_data_q  <= '0;
      b1_addr_q   <= '0;
      b1_wstrb_q  <= '0;
      b1_data_q   <= '0;
      split_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d && (nb_d != '0)) begin
            state_q     <= BEAT0;
            req_ready_q <= 1'b0;
            out_valid_q <= 1'b1;
            out_addr_q  <= base_d;
            out_wstrb_q <= m2_d[N-1:0];
            out_data_q  <= d2_d[DW-1:0];
            b1_addr_q   <= base_d + ADDR_W'(N);
            b1_wstrb_q  <= m2_d[2*N-1:N];
            b1_data_q   <= d2_d[2*DW-1:DW];
            split_q     <= split_d;
          end
        end
        BEAT0: begin
          if (hs_d) begin
            if (split_q) begin
              state_q     <= BEAT1;
              out_addr_q  <= b1_addr_q;
              out_wstrb_q <= b1_wstrb_q;
              out_data_q  <= b1_data_q;
            end else begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              req_ready_q <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (hs_d) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready_o = req_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_addr_o  = out_addr_q;
  assign bus.out_wstrb_o = out_wstrb_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_iob_byte_offset2wstrb_wr.sv
// Self-checking bench for the byte-offset write beat generator (N=4, ADDR_W=8).
// A byte-level model predicts the beats of each accepted request; a monitor
// compares every cycle against it, and directed cases pin literal results.
module tb_iob_byte_offset2wstrb_wr;
  import iob_byte_offset2wstrb_pkg::*;

  localparam int unsigned N      = BUS_BYTES;
  localparam int unsigned ADDR_W = 8;

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] data;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    checks = 0;
  int    failures = 0;
  int    readyMode = 0;
  beat_t expQ[$];
  bit    justReset = 1'b0;
  bit    lastValid = 1'b0;
  bit    lastReady = 1'b0;
  beat_t lastBeat;

  iob_byte_offset2wstrb_wr_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

  iob_byte_offset2wstrb_wr #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Byte-by-byte model: each written byte lands at absolute address addr+k
  // (mod 256); its word picks the beat, its low bits pick the lane.
  function automatic void modelRequest(input logic [7:0] addr, input logic [NB_W-1:0] nbReq,
                                       input logic [31:0] data);
    int    n;
    int    off;
    int    used;
    beat_t b[2];
    n    = (int'(nbReq) > 4) ? 4 : int'(nbReq);
    off  = int'(addr) % 4;
    used = 0;
    b[0] = '{8'h00, 4'h0, 32'h0};
    b[1] = '{8'h00, 4'h0, 32'h0};
    for (int k = 0; k < n; k++) begin
      int a;
      int idx;
      int lane;
      a    = (int'(addr) + k) % 256;
      idx  = (off + k) / 4;
      lane = a % 4;
      b[idx].addr             = 8'(a - lane);
      b[idx].wstrb[lane]      = 1'b1;
      b[idx].data[8*lane +: 8] = data[8*k +: 8];
      if (idx > used) used = idx;
    end
    if (n > 0) begin
      expQ.push_back(b[0]);
      if (used == 1) expQ.push_back(b[1]);
    end
  endfunction

  // Present one request and hold it until it is accepted (bounded).
  task automatic applyStimulus(input logic [7:0] addr, input logic [NB_W-1:0] nb, input logic [31:0] data);
    bit accepted;
    @(posedge clk); #1;
    bus.req_valid_i  = 1'b1;
    bus.req_addr_i   = addr;
    bus.req_nbytes_i = nb;
    bus.req_data_i   = data;
    accepted = 1'b0;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      if (bus.req_ready_o) accepted = 1'b1;
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  // Wait for the next completed beat and compare it to literal values.
  task automatic waitBeat(input string name, input logic [7:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] data);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.out_valid_o && bus.out_ready_i) begin
        found = 1'b1;
        checkOutput({name, "_addr"},  32'(bus.out_addr_o),  32'(addr));
        checkOutput({name, "_wstrb"}, 32'(bus.out_wstrb_o), 32'(wstrb));
        checkOutput({name, "_data"},  bus.out_data_o,       data);
      end
    end
    if (!found) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Beat consumer: always ready, random, or stalled 3 cycles on every beat.
  initial begin
    int waitCnt;
    bit prevValid;
    bit prevReady;
    waitCnt = 0;
    prevValid = 1'b0;
    prevReady = 1'b0;
    bus.out_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if ((prevValid && prevReady) || !bus.out_valid_o) waitCnt = 0;
      case (readyMode)
        0:       bus.out_ready_i = 1'b1;
        1:       bus.out_ready_i = ($urandom_range(0, 3) != 0);
        default: bus.out_ready_i = (waitCnt >= 3);
      endcase
      if (bus.out_valid_o) waitCnt++;
      prevValid = bus.out_valid_o;
      prevReady = bus.out_ready_i;
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expQ.delete();
        justReset = 1'b1;
        lastValid = 1'b0;
      end else begin
        if (justReset) begin
          checkOutput("reset_addr",  32'(bus.out_addr_o),  32'd0);
          checkOutput("reset_wstrb", 32'(bus.out_wstrb_o), 32'd0);
          checkOutput("reset_data",  bus.out_data_o,       32'd0);
          justReset = 1'b0;
        end
        checkOutput("req_ready", 32'(bus.req_ready_o), 32'(expQ.size() == 0));
        checkOutput("busy",      32'(bus.busy_o),      32'(expQ.size() != 0));
        checkOutput("out_valid", 32'(bus.out_valid_o), 32'(expQ.size() != 0));
        if (bus.out_valid_o && expQ.size() > 0) begin
          checkOutput("beat_addr",  32'(bus.out_addr_o),  32'(expQ[0].addr));
          checkOutput("beat_wstrb", 32'(bus.out_wstrb_o), 32'(expQ[0].wstrb));
          checkOutput("beat_data",  bus.out_data_o,       expQ[0].data);
        end
        if (lastValid && !lastReady) begin
          checkOutput("stall_valid", 32'(bus.out_valid_o), 32'd1);
          checkOutput("stall_addr",  32'(bus.out_addr_o),  32'(lastBeat.addr));
          checkOutput("stall_wstrb", 32'(bus.out_wstrb_o), 32'(lastBeat.wstrb));
          checkOutput("stall_data",  bus.out_data_o,       lastBeat.data);
        end
        lastValid = bus.out_valid_o;
        lastReady = bus.out_ready_i;
        lastBeat  = '{bus.out_addr_o, bus.out_wstrb_o, bus.out_data_o};
        if (bus.out_valid_o && bus.out_ready_i && expQ.size() > 0) void'(expQ.pop_front());
        if (bus.req_valid_i && bus.req_ready_o)
          modelRequest(bus.req_addr_i, bus.req_nbytes_i, bus.req_data_i);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed cases followed by randomized traffic.
  initial begin
    bit found;
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_nbytes_i = '0;
    bus.req_data_i   = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    readyMode = 0;
    applyStimulus(8'h10, NB_W'(4), 32'hDDCCBBAA);
    waitBeat("aligned", 8'h10, 4'b1111, 32'hDDCCBBAA);

    applyStimulus(8'h13, NB_W'(1), 32'h000000EE);
    waitBeat("toplane", 8'h10, 4'b1000, 32'hEE000000);

    applyStimulus(8'h22, NB_W'(4), 32'h44332211);
    waitBeat("split_b0", 8'h20, 4'b1100, 32'h22110000);
    waitBeat("split_b1", 8'h24, 4'b0011, 32'h00004433);

    readyMode = 2;
    applyStimulus(8'hFE, NB_W'(4), 32'h87654321);
    waitBeat("wrap_b0", 8'hFC, 4'b1100, 32'h43210000);
    waitBeat("wrap_b1", 8'h00, 4'b0011, 32'h00008765);

    readyMode = 0;
    applyStimulus(8'h05, NB_W'(0), 32'h12345678);
    @(negedge clk);
    checkOutput("zero_ready", 32'(bus.req_ready_o), 32'd1);
    checkOutput("zero_valid", 32'(bus.out_valid_o), 32'd0);

    applyStimulus(8'h01, NB_W'(7), 32'hA1B2C3D4);
    waitBeat("sat_b0", 8'h00, 4'b1110, 32'hB2C3D400);
    waitBeat("sat_b1", 8'h04, 4'b0001, 32'h000000A1);

    readyMode = 2;
    applyStimulus(8'h23, NB_W'(3), 32'h00CCBBAA);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.out_valid_o && bus.out_wstrb_o == 4'b0011 && !bus.out_ready_i) found = 1'b1;
    end
    if (!found) checkOutput("midreset_beat1_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset_valid", 32'(bus.out_valid_o), 32'd0);
    checkOutput("midreset_busy",  32'(bus.busy_o),      32'd0);
    checkOutput("midreset_ready", 32'(bus.req_ready_o), 32'd1);
    repeat (6) @(posedge clk);

    readyMode = 1;
    for (int r = 0; r < 300; r++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      applyStimulus(8'($urandom), NB_W'($urandom_range(0, 7)), $urandom);
    end

    readyMode = 0;
    for (int c = 0; c < 200 && expQ.size() != 0; c++) @(posedge clk);
    if (expQ.size() != 0) checkOutput("drain", 32'(expQ.size()), 32'd0);
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
